ddr_arbiter: RTL and testbench



---
 rtl/ddr_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_ddr_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_arbiter
//  Description : Round-robin, burst-granular arbiter sharing one Avalon-MM
//                DDR3 master port between three burst requesters.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int BURST_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,

    input  logic                      in0_rd,
    input  logic                      in0_wr,
    input  logic [ADDR_WIDTH-1:0]     in0_addr,
    input  logic [BURST_WIDTH-1:0]    in0_burstLength,
    input  logic [DATA_WIDTH/8-1:0]   in0_mask,
    input  logic [DATA_WIDTH-1:0]     in0_din,
    output logic                      in0_waitReq,
    output logic                      in0_valid,
    output logic [DATA_WIDTH-1:0]     in0_dout,

    input  logic                      in1_rd,
    input  logic                      in1_wr,
    input  logic [ADDR_WIDTH-1:0]     in1_addr,
    input  logic [BURST_WIDTH-1:0]    in1_burstLength,
    input  logic [DATA_WIDTH/8-1:0]   in1_mask,
    input  logic [DATA_WIDTH-1:0]     in1_din,
    output logic                      in1_waitReq,
    output logic                      in1_valid,
    output logic [DATA_WIDTH-1:0]     in1_dout,

    input  logic                      in2_rd,
    input  logic                      in2_wr,
    input  logic [ADDR_WIDTH-1:0]     in2_addr,
    input  logic [BURST_WIDTH-1:0]    in2_burstLength,
    input  logic [DATA_WIDTH/8-1:0]   in2_mask,
    input  logic [DATA_WIDTH-1:0]     in2_din,
    output logic                      in2_waitReq,
    output logic                      in2_valid,
    output logic [DATA_WIDTH-1:0]     in2_dout,

    output logic                      ddr_rd,
    output logic                      ddr_wr,
    output logic [ADDR_WIDTH-1:0]     ddr_addr,
    output logic [BURST_WIDTH-1:0]    ddr_burstLength,
    output logic [DATA_WIDTH/8-1:0]   ddr_mask,
    output logic [DATA_WIDTH-1:0]     ddr_din,
    input  logic                      ddr_waitReq,
    input  logic                      ddr_valid,
    input  logic [DATA_WIDTH-1:0]     ddr_dout,

    output logic [1:0]                grant
);

    localparam logic [1:0]             c_NONE = 2'd3;
    localparam logic [BURST_WIDTH-1:0] c_ONE  = BURST_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t                  r_state_q, w_state_d;
    logic [1:0]              r_grant_q, w_grant_d;
    logic [1:0]              r_last_q,  w_last_d;
    logic [BURST_WIDTH-1:0]  r_cnt_q,   w_cnt_d;

    logic [2:0]              w_rd, w_wr, w_req, w_wait, w_valid;
    logic [ADDR_WIDTH-1:0]   w_addr [3];
    logic [BURST_WIDTH-1:0]  w_blen [3];
    logic [DATA_WIDTH/8-1:0] w_mask [3];
    logic [DATA_WIDTH-1:0]   w_din  [3];
    logic [1:0]              w_gi, w_pick;
    logic [BURST_WIDTH-1:0]  w_len, w_eff;
    logic                    w_g_rd, w_g_wr;

    assign w_rd  = {in2_rd, in1_rd, in0_rd};
    assign w_wr  = {in2_wr, in1_wr, in0_wr};
    assign w_req = w_rd | w_wr;

    assign w_addr[0] = in0_addr;        assign w_addr[1] = in1_addr;        assign w_addr[2] = in2_addr;
    assign w_blen[0] = in0_burstLength; assign w_blen[1] = in1_burstLength; assign w_blen[2] = in2_burstLength;
    assign w_mask[0] = in0_mask;        assign w_mask[1] = in1_mask;        assign w_mask[2] = in2_mask;
    assign w_din[0]  = in0_din;         assign w_din[1]  = in1_din;         assign w_din[2]  = in2_din;

    // The "none" grant code folds onto port 0 so the data muxes never see index 3.
    assign w_gi   = (r_grant_q == c_NONE) ? 2'd0 : r_grant_q;
    assign w_g_rd = w_rd[w_gi];
    assign w_g_wr = w_wr[w_gi];
    assign w_len  = w_blen[w_gi];
    assign w_eff  = (w_len == '0) ? c_ONE : w_len;

    assign ddr_addr        = w_addr[w_gi];
    assign ddr_burstLength = w_len;
    assign ddr_mask        = w_mask[w_gi];
    assign ddr_din         = w_din[w_gi];

    // Priority rotates so the port after the last winner is considered first.
    always_comb begin
        w_pick = c_NONE;
        case (r_last_q)
            2'd0: begin
                if      (w_req[1]) w_pick = 2'd1;
                else if (w_req[2]) w_pick = 2'd2;
                else if (w_req[0]) w_pick = 2'd0;
            end
            2'd1: begin
                if      (w_req[2]) w_pick = 2'd2;
                else if (w_req[0]) w_pick = 2'd0;
                else if (w_req[1]) w_pick = 2'd1;
            end
            default: begin
                if      (w_req[0]) w_pick = 2'd0;
                else if (w_req[1]) w_pick = 2'd1;
                else if (w_req[2]) w_pick = 2'd2;
            end
        endcase
    end

    always_comb begin
        w_state_d = r_state_q;
        w_grant_d = r_grant_q;
        w_last_d  = r_last_q;
        w_cnt_d   = r_cnt_q;
        ddr_rd    = 1'b0;
        ddr_wr    = 1'b0;
        w_wait    = 3'b111;
        w_valid   = 3'b000;
        case (r_state_q)
            ST_IDLE: begin
                if (w_pick != c_NONE) begin
                    w_grant_d = w_pick;
                    w_last_d  = w_pick;
                    w_state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                ddr_rd         = w_g_rd;
                ddr_wr         = w_g_wr & ~w_g_rd;
                w_wait[w_gi]   = ddr_waitReq;
                if ((w_g_rd | w_g_wr) && !ddr_waitReq) begin
                    if (w_g_rd) begin
                        w_cnt_d   = w_eff;
                        w_state_d = ST_READ;
                    end else if (w_eff == c_ONE) begin
                        w_grant_d = c_NONE;
                        w_state_d = ST_IDLE;
                    end else begin
                        w_cnt_d   = w_eff - c_ONE;
                        w_state_d = ST_WRITE;
                    end
                end
            end
            ST_READ: begin
                w_valid[w_gi] = ddr_valid;
                if (ddr_valid) begin
                    w_cnt_d = r_cnt_q - c_ONE;
                    if (r_cnt_q == c_ONE) begin
                        w_grant_d = c_NONE;
                        w_state_d = ST_IDLE;
                    end
                end
            end
            ST_WRITE: begin
                ddr_wr       = w_g_wr;
                w_wait[w_gi] = ddr_waitReq;
                if (w_g_wr && !ddr_waitReq) begin
                    w_cnt_d = r_cnt_q - c_ONE;
                    if (r_cnt_q == c_ONE) begin
                        w_grant_d = c_NONE;
                        w_state_d = ST_IDLE;
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_grant_q <= c_NONE;
            r_last_q  <= 2'd2;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_grant_q <= w_grant_d;
            r_last_q  <= w_last_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign in0_waitReq = w_wait[0];
    assign in1_waitReq = w_wait[1];
    assign in2_waitReq = w_wait[2];
    assign in0_valid   = w_valid[0];
    assign in1_valid   = w_valid[1];
    assign in2_valid   = w_valid[2];
    assign in0_dout    = ddr_dout;
    assign in1_dout    = ddr_dout;
    assign in2_dout    = ddr_dout;
    assign grant       = r_grant_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr_arbiter
//  Description : Randomised scoreboard bench for ddr_arbiter against a
//                burst-ownership reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_arbiter;
    localparam int c_AW = 32;
    localparam int c_DW = 64;
    localparam int c_BW = 8;
    localparam int c_MW = c_DW / 8;
    localparam int c_PH_IDLE = 0, c_PH_CMD = 1, c_PH_READ = 2, c_PH_WRITE = 3;

    typedef struct { bit is_rd; logic [c_AW-1:0] a; logic [c_BW-1:0] l; } cmd_t;
    typedef struct { logic [c_DW-1:0] d; logic [c_MW-1:0] m; } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [2:0] rd = '0, wr = '0;
    logic [c_AW-1:0] addr [3];
    logic [c_BW-1:0] blen [3];
    logic [c_MW-1:0] mask [3];
    logic [c_DW-1:0] din  [3];
    wire  [2:0]      wait_o, valid_o;
    wire  [c_DW-1:0] dout [3];
    wire             ddr_rd, ddr_wr;
    wire  [c_AW-1:0] ddr_addr;
    wire  [c_BW-1:0] ddr_bl;
    wire  [c_MW-1:0] ddr_mask;
    wire  [c_DW-1:0] ddr_din;
    wire  [1:0]      grant;
    logic            ddr_waitReq = 1'b0, ddr_valid = 1'b0;
    logic [c_DW-1:0] ddr_dout = '0;

    cmd_t  cmdq [3][$];
    beat_t wq   [3][$];
    logic [c_DW-1:0] rdq [$];

    int m_owner = 3, m_last = 2, m_phase = 0, m_rem = 0;
    int m_rd_total = 0, n_issued = 0;
    bit [2:0] racc = '0;
    bit stop = 1'b0, ddr_en = 1'b0;
    int n_cmp = 0, n_err = 0;

    ddr_arbiter dut (
        .clock(clk), .reset(reset),
        .in0_rd(rd[0]), .in0_wr(wr[0]), .in0_addr(addr[0]), .in0_burstLength(blen[0]),
        .in0_mask(mask[0]), .in0_din(din[0]), .in0_waitReq(wait_o[0]), .in0_valid(valid_o[0]), .in0_dout(dout[0]),
        .in1_rd(rd[1]), .in1_wr(wr[1]), .in1_addr(addr[1]), .in1_burstLength(blen[1]),
        .in1_mask(mask[1]), .in1_din(din[1]), .in1_waitReq(wait_o[1]), .in1_valid(valid_o[1]), .in1_dout(dout[1]),
        .in2_rd(rd[2]), .in2_wr(wr[2]), .in2_addr(addr[2]), .in2_burstLength(blen[2]),
        .in2_mask(mask[2]), .in2_din(din[2]), .in2_waitReq(wait_o[2]), .in2_valid(valid_o[2]), .in2_dout(dout[2]),
        .ddr_rd(ddr_rd), .ddr_wr(ddr_wr), .ddr_addr(ddr_addr), .ddr_burstLength(ddr_bl),
        .ddr_mask(ddr_mask), .ddr_din(ddr_din), .ddr_waitReq(ddr_waitReq), .ddr_valid(ddr_valid),
        .ddr_dout(ddr_dout), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int eff(input logic [c_BW-1:0] l);
        return (l == '0) ? 1 : int'(l);
    endfunction

    task automatic check_beat(input int o);
        beat_t b;
        chk("wbeat_queued", 64'(wq[o].size() != 0), 64'd1);
        if (wq[o].size() != 0) begin
            b = wq[o].pop_front();
            chk("wbeat_din", ddr_din, b.d);
            chk("wbeat_mask", 64'(ddr_mask), 64'(b.m));
        end
    endtask

    // Reference model: who owns the DDR port, and how many beats remain.
    always @(negedge clk) begin : monitor
        int o;
        bit erd, ewr, ew, ev;
        cmd_t c;
        racc = '0;
        if (reset) begin
            m_owner = 3; m_last = 2; m_phase = c_PH_IDLE; m_rem = 0;
        end else begin
            o = m_owner;
            chk("grant", 64'(grant), 64'(m_owner));
            for (int p = 0; p < 3; p++) begin
                ew = 1'b1;
                ev = 1'b0;
                if (p == o && (m_phase == c_PH_CMD || m_phase == c_PH_WRITE)) ew = ddr_waitReq;
                if (p == o && m_phase == c_PH_READ) ev = ddr_valid;
                chk($sformatf("in%0d_waitReq", p), 64'(wait_o[p]), 64'(ew));
                chk($sformatf("in%0d_valid", p), 64'(valid_o[p]), 64'(ev));
            end
            erd = 1'b0;
            ewr = 1'b0;
            if (m_phase == c_PH_CMD) begin
                erd = rd[o];
                ewr = wr[o] & ~rd[o];
            end else if (m_phase == c_PH_WRITE) begin
                ewr = wr[o];
            end
            chk("ddr_rd", 64'(ddr_rd), 64'(erd));
            chk("ddr_wr", 64'(ddr_wr), 64'(ewr));

            case (m_phase)
                c_PH_IDLE: begin
                    for (int k = 1; k <= 3; k++) begin
                        int cand;
                        cand = (m_last + k) % 3;
                        if (m_owner == 3 && (rd[cand] | wr[cand])) m_owner = cand;
                    end
                    if (m_owner != 3) begin
                        m_last  = m_owner;
                        m_phase = c_PH_CMD;
                    end
                end
                c_PH_CMD: if ((rd[o] | wr[o]) && !ddr_waitReq) begin
                    racc[o] = 1'b1;
                    chk("cmd_queued", 64'(cmdq[o].size() != 0), 64'd1);
                    if (cmdq[o].size() != 0) begin
                        c = cmdq[o].pop_front();
                        chk("cmd_addr", 64'(ddr_addr), 64'(c.a));
                        chk("cmd_len", 64'(ddr_bl), 64'(c.l));
                        chk("cmd_is_rd", 64'(ddr_rd), 64'(c.is_rd));
                    end
                    if (rd[o]) begin
                        m_phase = c_PH_READ;
                        m_rem = eff(blen[o]);
                        m_rd_total += m_rem;
                    end else begin
                        check_beat(o);
                        if (eff(blen[o]) == 1) begin
                            m_owner = 3; m_phase = c_PH_IDLE;
                        end else begin
                            m_phase = c_PH_WRITE; m_rem = eff(blen[o]) - 1;
                        end
                    end
                end
                c_PH_READ: if (ddr_valid) begin
                    chk("rdata_queued", 64'(rdq.size() != 0), 64'd1);
                    if (rdq.size() != 0) chk("rdata", dout[o], rdq.pop_front());
                    m_rem--;
                    if (m_rem == 0) begin m_owner = 3; m_phase = c_PH_IDLE; end
                end
                c_PH_WRITE: if (wr[o] && !ddr_waitReq) begin
                    racc[o] = 1'b1;
                    check_beat(o);
                    m_rem--;
                    if (m_rem == 0) begin m_owner = 3; m_phase = c_PH_IDLE; end
                end
                default: ;
            endcase
        end
    end

    // DDR slave: random stalls, read beats with random latency, occasional stray valid.
    initial begin : ddr_slave
        forever begin
            @(posedge clk); #1;
            ddr_waitReq = ddr_en ? ($urandom_range(0, 9) < 3) : 1'b0;
            ddr_valid = 1'b0;
            if ((m_rd_total - n_issued) > 0 && $urandom_range(0, 3) != 0) begin
                ddr_dout  = {$urandom, $urandom};
                ddr_valid = 1'b1;
                n_issued++;
                rdq.push_back(ddr_dout);
            end else if ((m_rd_total - n_issued) == 0 && ddr_en && $urandom_range(0, 24) == 0) begin
                ddr_dout  = {$urandom, $urandom};
                ddr_valid = 1'b1;
            end
        end
    end

    task automatic drive_port(input int p);
        int l, kind, n;
        logic [c_AW-1:0] a;
        beat_t bt;
        while (!stop) begin
            repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
            a = $urandom;
            l = $urandom_range(0, 6);
            kind = $urandom_range(0, 9);
            addr[p] = a;
            blen[p] = c_BW'(l);
            mask[p] = c_MW'($urandom);
            if (kind < 5) begin
                cmdq[p].push_back('{1'b1, a, c_BW'(l)});
                rd[p] = 1'b1;
                wr[p] = (kind == 0);
                do begin @(posedge clk); #1; end while (!racc[p]);
                rd[p] = 1'b0;
                wr[p] = 1'b0;
            end else begin
                n = (l == 0) ? 1 : l;
                cmdq[p].push_back('{1'b0, a, c_BW'(l)});
                for (int b = 0; b < n; b++) begin
                    bt.d = {$urandom, $urandom};
                    bt.m = c_MW'($urandom);
                    wq[p].push_back(bt);
                    din[p] = bt.d;
                    mask[p] = bt.m;
                    wr[p] = 1'b1;
                    do begin @(posedge clk); #1; end while (!racc[p]);
                    if (b < n - 1 && $urandom_range(0, 3) == 0) begin
                        wr[p] = 1'b0;
                        @(posedge clk); #1;
                    end
                end
                wr[p] = 1'b0;
            end
        end
    endtask

    task automatic wait_quiet(input string name);
        int i;
        for (i = 0; i < 400; i++) begin
            if (rd == '0 && wr == '0 && m_phase == c_PH_IDLE && m_rd_total == n_issued) break;
            @(posedge clk); #1;
        end
        if (i == 400) begin
            n_cmp++; n_err++;
            $display("FAIL %s: timeout waiting for idle, got phase %0d, required %0d", name, m_phase, c_PH_IDLE);
        end
        @(negedge clk);
        chk(name, 64'(grant), 64'd3);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1);
    end

    initial begin : main
        logic [c_DW-1:0] bd [5];
        int nb;
        for (int p = 0; p < 3; p++) begin
            addr[p] = '0; blen[p] = '0; mask[p] = '0; din[p] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 64'(grant), 64'd3);
        chk("rst_ddr_rd", 64'(ddr_rd), 64'd0);
        chk("rst_ddr_wr", 64'(ddr_wr), 64'd0);
        chk("rst_waitReq", 64'(wait_o), 64'b111);
        chk("rst_valid", 64'(valid_o), 64'b000);
        @(posedge clk); #1;
        reset  = 1'b0;
        ddr_en = 1'b1;

        fork
            drive_port(0);
            drive_port(1);
            drive_port(2);
            begin repeat (4000) @(posedge clk); stop = 1'b1; end
        join
        wait_quiet("drain_grant");

        // Reset in the middle of a 5-beat write from port 0.
        ddr_en = 1'b0;
        @(posedge clk); #1;
        addr[0] = 32'h0000_2000;
        blen[0] = 8'd5;
        mask[0] = 8'hFF;
        cmdq[0].push_back('{1'b0, 32'h0000_2000, 8'd5});
        for (int b = 0; b < 5; b++) begin
            bd[b] = {$urandom, $urandom};
            wq[0].push_back('{bd[b], 8'hFF});
        end
        din[0] = bd[0];
        wr[0]  = 1'b1;
        nb = 0;
        for (int i = 0; i < 20 && nb < 2; i++) begin
            @(posedge clk); #1;
            if (racc[0]) begin
                nb++;
                din[0] = bd[nb];
            end
        end
        chk("beats_before_reset", 64'(nb), 64'd2);
        reset = 1'b1;
        wr[0] = 1'b0;
        wq[0].delete();
        for (int p = 0; p < 3; p++) begin
            addr[p] = 32'h0000_3000 + 32'(p * 16);
            blen[p] = 8'd1;
            cmdq[p].push_back('{1'b1, addr[p], 8'd1});
            rd[p] = 1'b1;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", 64'(grant), 64'd3);
        chk("post_rst_ddr_wr", 64'(ddr_wr), 64'd0);
        chk("post_rst_waitReq", 64'(wait_o), 64'b111);
        @(negedge clk);
        chk("first_grant_after_rst", 64'(grant), 64'd0);
        for (int i = 0; i < 100 && rd != '0; i++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 3; p++) if (racc[p]) rd[p] = 1'b0;
        end
        wait_quiet("final_grant");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
